// File: rtl/pio_arb_if.sv
// PIO arbiter bus bundle: N master command ports plus the single slave port.
// master modport is the environment side (masters and slave device); slave modport is the arbiter.
interface pio_arb_if #(
  parameter int unsigned NUM_M = 4,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 32
) ();

  logic [NUM_M-1:0]    m_cmd_vld;
  logic [NUM_M-1:0]    m_cmd_rdy;
  logic [NUM_M*AW-1:0] m_addr;
  logic [NUM_M*DW-1:0] m_data_w;
  logic [NUM_M-1:0]    m_rw;
  logic [DW-1:0]       m_data_r;
  logic [NUM_M-1:0]    m_rd_vld;
  logic                s_cmd_vld;
  logic [AW-1:0]       s_addr;
  logic [DW-1:0]       s_data_w;
  logic                s_rw;
  logic [DW-1:0]       s_data_r;
  logic                s_rd_vld;
  logic                timeout_err;

  modport master (
    output m_cmd_vld, m_addr, m_data_w, m_rw, s_data_r, s_rd_vld,
    input  m_cmd_rdy, m_data_r, m_rd_vld, s_cmd_vld, s_addr, s_data_w, s_rw, timeout_err
  );

  modport slave (
    input  m_cmd_vld, m_addr, m_data_w, m_rw, s_data_r, s_rd_vld,
    output m_cmd_rdy, m_data_r, m_rd_vld, s_cmd_vld, s_addr, s_data_w, s_rw, timeout_err
  );

endinterface

// File: rtl/pio_arb.sv
// Round-robin N-master to 1-slave PIO arbiter with single outstanding read.
// Optional read timeout enabled by defining PIO_ARB_TIMEOUT_EN.
module pio_arb #(
  parameter int unsigned NUM_M      = 4,
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 32,
  parameter int unsigned RD_TIMEOUT = 256
) (
  input logic       clk,
  input logic       rst_n,
  pio_arb_if.slave  bus
);

  localparam int unsigned IW = $clog2(NUM_M);

  if (NUM_M < 2) begin : g_bad_num_m
    $error("pio_arb: NUM_M must be at least 2");
  end
  if (RD_TIMEOUT < 1) begin : g_bad_rd_timeout
    $error("pio_arb: RD_TIMEOUT must be at least 1");
  end

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  state_e            state_q;
  logic [IW-1:0]     last_grant_q;
  logic [IW-1:0]     owner_q;
  logic              s_cmd_vld_q;
  logic [AW-1:0]     s_addr_q;
  logic [DW-1:0]     s_data_w_q;
  logic              s_rw_q;
  logic [NUM_M-1:0]  m_rd_vld_q;
  logic [DW-1:0]     m_data_r_q;

  logic [IW-1:0]     rr_idx;
  logic [IW-1:0]     grant_idx;
  logic              grant_vld;
  logic              accept;
  logic [NUM_M-1:0]  cmd_rdy;
  logic [NUM_M-1:0]  owner_onehot;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_data_w;
  logic              sel_rw;

  // First requester strictly after the last grant, wrapping NUM_M-1 -> 0.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = '0;
    for (int unsigned k = 1; k <= NUM_M; k++) begin
      rr_idx = IW'((32'(last_grant_q) + k) % NUM_M);
      if (!grant_vld && bus.m_cmd_vld[rr_idx]) begin
        grant_vld = 1'b1;
        grant_idx = rr_idx;
      end
    end
  end

  assign accept = (state_q == StIdle) && grant_vld;

  always_comb begin
    cmd_rdy = '0;
    if (accept) begin
      cmd_rdy[grant_idx] = 1'b1;
    end
  end

  assign owner_onehot = NUM_M'(1) << owner_q;
  assign sel_addr     = bus.m_addr[32'(grant_idx)*AW +: AW];
  assign sel_data_w   = bus.m_data_w[32'(grant_idx)*DW +: DW];
  assign sel_rw       = bus.m_rw[grant_idx];

`ifdef PIO_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(RD_TIMEOUT + 1);
  logic [CW-1:0] to_cnt_q;
  logic          timeout_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      last_grant_q  <= IW'(NUM_M - 1);
      owner_q       <= '0;
      s_cmd_vld_q   <= 1'b0;
      s_addr_q      <= '0;
      s_data_w_q    <= '0;
      s_rw_q        <= 1'b0;
      m_rd_vld_q    <= '0;
      m_data_r_q    <= '0;
`ifdef PIO_ARB_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      s_cmd_vld_q <= 1'b0;
      m_rd_vld_q  <= '0;
`ifdef PIO_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (accept) begin
            last_grant_q <= grant_idx;
            s_cmd_vld_q  <= 1'b1;
            s_addr_q     <= sel_addr;
            s_data_w_q   <= sel_data_w;
            s_rw_q       <= sel_rw;
            if (!sel_rw) begin
              state_q <= StRdWait;
              owner_q <= grant_idx;
`ifdef PIO_ARB_TIMEOUT_EN
              to_cnt_q <= '0;
`endif
            end
          end
        end
        StRdWait: begin
          // A real response beats a timeout landing in the same cycle.
          if (bus.s_rd_vld) begin
            m_data_r_q <= bus.s_data_r;
            m_rd_vld_q <= owner_onehot;
            state_q    <= StIdle;
          end
`ifdef PIO_ARB_TIMEOUT_EN
          else if (to_cnt_q == CW'(RD_TIMEOUT)) begin
            m_data_r_q    <= '1;
            m_rd_vld_q    <= owner_onehot;
            timeout_err_q <= 1'b1;
            state_q       <= StIdle;
          end else begin
            to_cnt_q <= to_cnt_q + CW'(1);
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.m_cmd_rdy = cmd_rdy;
  assign bus.m_rd_vld  = m_rd_vld_q;
  assign bus.m_data_r  = m_data_r_q;
  assign bus.s_cmd_vld = s_cmd_vld_q;
  assign bus.s_addr    = s_addr_q;
  assign bus.s_data_w  = s_data_w_q;
  assign bus.s_rw      = s_rw_q;
`ifdef PIO_ARB_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_pio_arb.sv
// Self-checking bench for pio_arb: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_pio_arb;

  localparam int unsigned NM = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pio_arb_if #(.NUM_M(NM), .AW(AW), .DW(DW)) bus ();

  pio_arb #(.NUM_M(NM), .AW(AW), .DW(DW), .RD_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_cmd_vld = '0;
    bus.m_addr    = '0;
    bus.m_data_w  = '0;
    bus.m_rw      = '0;
    bus.s_data_r  = '0;
    bus.s_rd_vld  = 1'b0;
  endtask

  task automatic set_m(input int i, input logic vld, input logic rw,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.m_cmd_vld[i]          = vld;
    bus.m_rw[i]               = rw;
    bus.m_addr[i*AW +: AW]    = a;
    bus.m_data_w[i*DW +: DW]  = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.m_cmd_vld = '1;
    cyc();
    n_checks++; if (bus.s_cmd_vld !== 1'b0) begin n_fail++; $display("FAIL rst_s_cmd_vld got %b exp 0", bus.s_cmd_vld); end
    n_checks++; if (bus.s_addr !== '0) begin n_fail++; $display("FAIL rst_s_addr got %h exp 0", bus.s_addr); end
    n_checks++; if (bus.s_data_w !== '0) begin n_fail++; $display("FAIL rst_s_data_w got %h exp 0", bus.s_data_w); end
    n_checks++; if (bus.s_rw !== 1'b0) begin n_fail++; $display("FAIL rst_s_rw got %b exp 0", bus.s_rw); end
    n_checks++; if (bus.m_rd_vld !== '0) begin n_fail++; $display("FAIL rst_m_rd_vld got %b exp 0", bus.m_rd_vld); end
    n_checks++; if (bus.m_data_r !== '0) begin n_fail++; $display("FAIL rst_m_data_r got %h exp 0", bus.m_data_r); end
    n_checks++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err got %b exp 0", bus.timeout_err); end
    n_checks++; if (bus.m_cmd_rdy !== 4'b0001) begin n_fail++; $display("FAIL rst_first_grant got %b exp 0001", bus.m_cmd_rdy); end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    cyc();
    set_m(2, 1'b1, 1'b1, 16'h0040, 32'hA5A5_0001);
    #1;
    n_checks++; if (bus.m_cmd_rdy !== 4'b0100) begin n_fail++; $display("FAIL sw_rdy got %b exp 0100", bus.m_cmd_rdy); end
    cyc();
    set_m(2, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++; if (bus.s_cmd_vld !== 1'b1) begin n_fail++; $display("FAIL sw_s_cmd_vld got %b exp 1", bus.s_cmd_vld); end
    n_checks++; if (bus.s_addr !== 16'h0040) begin n_fail++; $display("FAIL sw_s_addr got %h exp 0040", bus.s_addr); end
    n_checks++; if (bus.s_data_w !== 32'hA5A5_0001) begin n_fail++; $display("FAIL sw_s_data_w got %h exp a5a50001", bus.s_data_w); end
    n_checks++; if (bus.s_rw !== 1'b1) begin n_fail++; $display("FAIL sw_s_rw got %b exp 1", bus.s_rw); end
    n_checks++; if (bus.m_rd_vld !== '0) begin n_fail++; $display("FAIL sw_m_rd_vld got %b exp 0", bus.m_rd_vld); end
    cyc();
    n_checks++; if (bus.s_cmd_vld !== 1'b0) begin n_fail++; $display("FAIL sw_s_cmd_pulse got %b exp 0", bus.s_cmd_vld); end
  endtask

  task automatic test_rr_writes();
    logic [AW-1:0] addr [NM];
    int last = NM - 1;
    int prev_g = -1;
    logic [AW-1:0] prev_addr = '0;
    do_reset();
    cyc();
    for (int i = 0; i < NM; i++) begin
      addr[i] = AW'(i << 8);
      set_m(i, 1'b1, 1'b1, addr[i], DW'(i));
    end
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        cyc();
        set_m(prev_g, 1'b1, 1'b1, addr[prev_g], DW'(c));
      end
      #1;
      begin
        int g = (last + 1) % NM;
        n_checks++; if (bus.m_cmd_rdy !== NM'(1 << g)) begin n_fail++; $display("FAIL rr_order c=%0d got %b exp master %0d", c, bus.m_cmd_rdy, g); end
        if (c > 0) begin
          n_checks++; if (bus.s_cmd_vld !== 1'b1 || bus.s_addr !== prev_addr) begin n_fail++; $display("FAIL rr_s_cmd c=%0d got vld %b addr %h exp 1 %h", c, bus.s_cmd_vld, bus.s_addr, prev_addr); end
        end
        prev_addr = addr[g];
        addr[g]   = addr[g] + 1'b1;
        last      = g;
        prev_g    = g;
      end
    end
    cyc();
    clear_inputs();
  endtask

  task automatic test_read_hold();
    do_reset();
    cyc();
    set_m(1, 1'b1, 1'b0, 16'h0010, '0);
    set_m(3, 1'b1, 1'b1, 16'h0333, 32'h3333_0003);
    #1;
    n_checks++; if (bus.m_cmd_rdy !== 4'b0010) begin n_fail++; $display("FAIL rd_accept got %b exp 0010", bus.m_cmd_rdy); end
    cyc();
    set_m(1, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++; if (bus.s_cmd_vld !== 1'b1 || bus.s_rw !== 1'b0 || bus.s_addr !== 16'h0010) begin n_fail++; $display("FAIL rd_s_cmd got vld %b rw %b addr %h exp 1 0 0010", bus.s_cmd_vld, bus.s_rw, bus.s_addr); end
    n_checks++; if (bus.m_cmd_rdy !== 4'b0000) begin n_fail++; $display("FAIL rd_wait_hold1 got %b exp 0000", bus.m_cmd_rdy); end
    cyc();
    n_checks++; if (bus.m_cmd_rdy !== 4'b0000) begin n_fail++; $display("FAIL rd_wait_hold2 got %b exp 0000", bus.m_cmd_rdy); end
    cyc();
    bus.s_rd_vld = 1'b1;
    bus.s_data_r = 32'h1234_5678;
    #1;
    n_checks++; if (bus.m_cmd_rdy !== 4'b0000 || bus.m_rd_vld !== '0) begin n_fail++; $display("FAIL rd_wait_hold3 got rdy %b rd_vld %b exp 0000 0000", bus.m_cmd_rdy, bus.m_rd_vld); end
    cyc();
    bus.s_rd_vld = 1'b0;
    bus.s_data_r = '0;
    #1;
    n_checks++; if (bus.m_rd_vld !== 4'b0010) begin n_fail++; $display("FAIL rd_return_vld got %b exp 0010", bus.m_rd_vld); end
    n_checks++; if (bus.m_data_r !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_return_data got %h exp 12345678", bus.m_data_r); end
    n_checks++; if (bus.m_cmd_rdy !== 4'b1000) begin n_fail++; $display("FAIL rd_held_write_accept got %b exp 1000", bus.m_cmd_rdy); end
    cyc();
    set_m(3, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++; if (bus.s_cmd_vld !== 1'b1 || bus.s_addr !== 16'h0333 || bus.s_rw !== 1'b1) begin n_fail++; $display("FAIL rd_held_write_issue got vld %b addr %h rw %b exp 1 0333 1", bus.s_cmd_vld, bus.s_addr, bus.s_rw); end
    n_checks++; if (bus.m_rd_vld !== '0 || bus.m_data_r !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_data_hold got vld %b data %h exp 0000 12345678", bus.m_rd_vld, bus.m_data_r); end
  endtask

  task automatic test_same_cycle_read();
    do_reset();
    cyc();
    set_m(0, 1'b1, 1'b0, 16'h0020, '0);
    #1;
    n_checks++; if (bus.m_cmd_rdy !== 4'b0001) begin n_fail++; $display("FAIL sc_accept got %b exp 0001", bus.m_cmd_rdy); end
    cyc();
    set_m(0, 1'b0, 1'b0, '0, '0);
    bus.s_rd_vld = 1'b1;
    bus.s_data_r = 32'hCAFE_F00D;
    #1;
    n_checks++; if (bus.s_cmd_vld !== 1'b1) begin n_fail++; $display("FAIL sc_s_cmd_vld got %b exp 1", bus.s_cmd_vld); end
    cyc();
    bus.s_rd_vld = 1'b0;
    #1;
    n_checks++; if (bus.m_rd_vld !== 4'b0001 || bus.m_data_r !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL sc_return got vld %b data %h exp 0001 cafef00d", bus.m_rd_vld, bus.m_data_r); end
    cyc();
    bus.s_rd_vld = 1'b1;
    bus.s_data_r = 32'hDEAD_BEEF;
    cyc();
    bus.s_rd_vld = 1'b0;
    #1;
    n_checks++; if (bus.m_rd_vld !== '0 || bus.m_data_r !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL idle_rd_vld_ignored got vld %b data %h exp 0000 cafef00d", bus.m_rd_vld, bus.m_data_r); end
  endtask

  task automatic test_timeout();
    do_reset();
    cyc();
    set_m(0, 1'b1, 1'b0, 16'h0030, '0);
    set_m(1, 1'b1, 1'b1, 16'h0031, 32'h0000_0011);
    #1;
    n_checks++; if (bus.m_cmd_rdy !== 4'b0001) begin n_fail++; $display("FAIL to_accept got %b exp 0001", bus.m_cmd_rdy); end
    cyc();
    set_m(0, 1'b0, 1'b0, '0, '0);
`ifdef PIO_ARB_TIMEOUT_EN
    for (int w = 2; w <= 9; w++) begin
      cyc();
      n_checks++; if (bus.m_rd_vld !== '0 || bus.m_cmd_rdy !== '0 || bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_early w=%0d got vld %b rdy %b err %b exp 0 0 0", w, bus.m_rd_vld, bus.m_cmd_rdy, bus.timeout_err); end
    end
    cyc();
    n_checks++; if (bus.m_rd_vld !== 4'b0001) begin n_fail++; $display("FAIL to_rd_vld got %b exp 0001", bus.m_rd_vld); end
    n_checks++; if (bus.m_data_r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL to_data got %h exp ffffffff", bus.m_data_r); end
    n_checks++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err got %b exp 1", bus.timeout_err); end
    n_checks++; if (bus.m_cmd_rdy !== 4'b0010) begin n_fail++; $display("FAIL to_next_accept got %b exp 0010", bus.m_cmd_rdy); end
    cyc();
    set_m(1, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++; if (bus.timeout_err !== 1'b0 || bus.m_rd_vld !== '0) begin n_fail++; $display("FAIL to_pulse got err %b vld %b exp 0 0000", bus.timeout_err, bus.m_rd_vld); end
    n_checks++; if (bus.s_cmd_vld !== 1'b1 || bus.s_addr !== 16'h0031) begin n_fail++; $display("FAIL to_next_issue got vld %b addr %h exp 1 0031", bus.s_cmd_vld, bus.s_addr); end
`else
    for (int w = 2; w <= 21; w++) begin
      cyc();
      n_checks++; if (bus.m_rd_vld !== '0 || bus.m_cmd_rdy !== '0 || bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL nto_wait w=%0d got vld %b rdy %b err %b exp 0 0 0", w, bus.m_rd_vld, bus.m_cmd_rdy, bus.timeout_err); end
    end
    bus.s_rd_vld = 1'b1;
    bus.s_data_r = 32'h0BAD_CAFE;
    cyc();
    bus.s_rd_vld = 1'b0;
    #1;
    n_checks++; if (bus.m_rd_vld !== 4'b0001 || bus.m_data_r !== 32'h0BAD_CAFE) begin n_fail++; $display("FAIL nto_return got vld %b data %h exp 0001 0badcafe", bus.m_rd_vld, bus.m_data_r); end
    n_checks++; if (bus.m_cmd_rdy !== 4'b0010) begin n_fail++; $display("FAIL nto_next_accept got %b exp 0010", bus.m_cmd_rdy); end
    cyc();
    set_m(1, 1'b0, 1'b0, '0, '0);
`endif
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    cyc();
    set_m(2, 1'b1, 1'b0, 16'h0050, '0);
    #1;
    n_checks++; if (bus.m_cmd_rdy !== 4'b0100) begin n_fail++; $display("FAIL rmr_accept got %b exp 0100", bus.m_cmd_rdy); end
    cyc();
    set_m(2, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++; if (bus.s_cmd_vld !== 1'b1 || bus.m_cmd_rdy !== '0) begin n_fail++; $display("FAIL rmr_in_wait got vld %b rdy %b exp 1 0000", bus.s_cmd_vld, bus.m_cmd_rdy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.s_cmd_vld !== 1'b0 || bus.s_addr !== '0 || bus.s_rw !== 1'b0 || bus.s_data_w !== '0) begin n_fail++; $display("FAIL rmr_s_reset got vld %b addr %h rw %b data %h exp 0", bus.s_cmd_vld, bus.s_addr, bus.s_rw, bus.s_data_w); end
    n_checks++; if (bus.m_rd_vld !== '0 || bus.m_data_r !== '0 || bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL rmr_m_reset got vld %b data %h err %b exp 0", bus.m_rd_vld, bus.m_data_r, bus.timeout_err); end
    for (int i = 0; i < NM; i++) set_m(i, 1'b1, 1'b1, AW'(16'h0100 + i), DW'(i));
    #1;
    n_checks++; if (bus.m_cmd_rdy !== 4'b0001) begin n_fail++; $display("FAIL rmr_rdy_in_reset got %b exp 0001", bus.m_cmd_rdy); end
    cyc();
    rst_n = 1'b1;
    bus.s_rd_vld = 1'b1;
    bus.s_data_r = 32'h0000_0BAD;
    #1;
    n_checks++; if (bus.m_cmd_rdy !== 4'b0001) begin n_fail++; $display("FAIL rmr_first_grant got %b exp 0001", bus.m_cmd_rdy); end
    cyc();
    bus.s_rd_vld = 1'b0;
    set_m(0, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++; if (bus.m_rd_vld !== '0) begin n_fail++; $display("FAIL rmr_late_rsp_ignored got %b exp 0000", bus.m_rd_vld); end
    n_checks++; if (bus.s_cmd_vld !== 1'b1 || bus.s_addr !== 16'h0100) begin n_fail++; $display("FAIL rmr_issue got vld %b addr %h exp 1 0100", bus.s_cmd_vld, bus.s_addr); end
    n_checks++; if (bus.m_cmd_rdy !== 4'b0010) begin n_fail++; $display("FAIL rmr_second_grant got %b exp 0010", bus.m_cmd_rdy); end
    cyc();
    clear_inputs();
  endtask

  // Transaction-level model: pending requests per master, one read in flight.
  task automatic test_random();
    bit              pend [NM];
    logic [AW-1:0]   pa   [NM];
    logic [DW-1:0]   pd   [NM];
    bit              prw  [NM];
    int              last   = NM - 1;
    bit              busy   = 1'b0;
    int              owner  = 0;
    int              wait_n = 0;
    logic            e_s_vld = 1'b0;
    logic [AW-1:0]   e_s_addr = '0;
    logic [DW-1:0]   e_s_dw = '0;
    logic            e_s_rw = 1'b0;
    logic [NM-1:0]   e_rd_vld = '0;
    logic [DW-1:0]   e_data_r = '0;
    logic            e_to = 1'b0;
    for (int i = 0; i < NM; i++) pend[i] = 1'b0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bit            rsp;
      logic [DW-1:0] rdata;
      int            g;
      logic [NM-1:0] e_rdy;
      cyc();
      for (int i = 0; i < NM; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i]   = AW'($urandom);
          pd[i]   = DW'($urandom);
          prw[i]  = 1'($urandom_range(0, 1));
        end
        set_m(i, pend[i], prw[i], pa[i], pd[i]);
      end
      rsp   = busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      rdata = DW'($urandom);
      bus.s_rd_vld = rsp;
      bus.s_data_r = rdata;
      #1;
      g = -1;
      if (!busy) begin
        for (int k = 1; k <= NM; k++) begin
          int j = (last + k) % NM;
          if (g < 0 && pend[j]) g = j;
        end
      end
      e_rdy = (g >= 0) ? NM'(1 << g) : '0;
      n_checks++; if (bus.m_cmd_rdy !== e_rdy) begin n_fail++; $display("FAIL rnd_rdy c=%0d got %b exp %b", c, bus.m_cmd_rdy, e_rdy); end
      n_checks++; if (bus.s_cmd_vld !== e_s_vld) begin n_fail++; $display("FAIL rnd_s_cmd_vld c=%0d got %b exp %b", c, bus.s_cmd_vld, e_s_vld); end
      if (e_s_vld) begin
        n_checks++; if (bus.s_addr !== e_s_addr || bus.s_data_w !== e_s_dw || bus.s_rw !== e_s_rw) begin n_fail++; $display("FAIL rnd_s_payload c=%0d got %h %h %b exp %h %h %b", c, bus.s_addr, bus.s_data_w, bus.s_rw, e_s_addr, e_s_dw, e_s_rw); end
      end
      n_checks++; if (bus.m_rd_vld !== e_rd_vld) begin n_fail++; $display("FAIL rnd_m_rd_vld c=%0d got %b exp %b", c, bus.m_rd_vld, e_rd_vld); end
      n_checks++; if (bus.m_data_r !== e_data_r) begin n_fail++; $display("FAIL rnd_m_data_r c=%0d got %h exp %h", c, bus.m_data_r, e_data_r); end
      n_checks++; if (bus.timeout_err !== e_to) begin n_fail++; $display("FAIL rnd_timeout_err c=%0d got %b exp %b", c, bus.timeout_err, e_to); end
      e_s_vld  = 1'b0;
      e_rd_vld = '0;
      e_to     = 1'b0;
      if (busy) begin
        if (rsp) begin
          e_rd_vld = NM'(1 << owner);
          e_data_r = rdata;
          busy     = 1'b0;
        end
`ifdef PIO_ARB_TIMEOUT_EN
        else if (wait_n == TO) begin
          e_rd_vld = NM'(1 << owner);
          e_data_r = '1;
          e_to     = 1'b1;
          busy     = 1'b0;
        end
`endif
        else begin
          wait_n++;
        end
      end else if (g >= 0) begin
        e_s_vld  = 1'b1;
        e_s_addr = pa[g];
        e_s_dw   = pd[g];
        e_s_rw   = prw[g];
        last     = g;
        pend[g]  = 1'b0;
        if (!prw[g]) begin
          busy   = 1'b1;
          owner  = g;
          wait_n = 0;
        end
      end
    end
    cyc();
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_write();
    test_rr_writes();
    test_read_hold();
    test_same_cycle_read();
    test_timeout();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_arb.md
# pio_arb

Parametrised N-master to 1-slave arbiter for the PIO bus. It generalises the single-master PIO link to configurable address and data widths and master count. Each master gets a valid/ready command handshake, and the block arbitrates round-robin, tracks the single outstanding read, and routes read data back to its originator. It sits between CPU-side or test-side PIO masters and one PIO register slave.

## Interface
Parameters:
- NUM_M, default 4: number of master ports; minimum 2.
- AW, default 16: address width.
- DW, default 32: data width.
- RD_TIMEOUT, default 256: read-wait cycle limit; used only with PIO_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m_cmd_vld  in  NUM_M  per-master command valid.
- m_cmd_rdy  out  NUM_M  per-master command accept.
- m_addr  in  NUM_M*AW  packed addresses; master i at [i*AW +: AW].
- m_data_w  in  NUM_M*DW  packed write data.
- m_rw  in  NUM_M  0 = read, 1 = write.
- m_data_r  out  DW  read data, shared by all masters.
- m_rd_vld  out  NUM_M  one-hot read-return strobe.
- s_cmd_vld  out  1  slave command valid; one-cycle pulse per command.
- s_addr  out  AW  slave address.
- s_data_w  out  DW  slave write data.
- s_rw  out  1  slave read/write.
- s_data_r  in  DW  slave read data.
- s_rd_vld  in  1  slave read data valid.
- timeout_err  out  1  one-cycle pulse on read timeout; tied 0 without the macro.

## Operation
- States: IDLE, RD_WAIT.
- IDLE:
  - The round-robin arbiter picks one requester among the m_cmd_vld bits. Search starts at last_grant+1 and wraps at NUM_M-1 → 0.
  - m_cmd_rdy[g] = 1 for the granted master only. This is combinational from m_cmd_vld and state.
  - Accept occurs when m_cmd_vld[g] and m_cmd_rdy[g] are both 1. On accept, last_grant ← g and the payload is registered onto the s_* outputs.
  - A write accept stays in IDLE; writes are posted and need no response.
  - A read accept moves to RD_WAIT and records owner ← g.
- RD_WAIT:
  - All m_cmd_rdy = 0.
  - When s_rd_vld = 1: m_data_r ← s_data_r, m_rd_vld ← onehot(owner), and state returns to IDLE.
- Masters must hold addr, data_w and rw stable while m_cmd_vld = 1 and m_cmd_rdy = 0. A master must not drop m_cmd_vld before it is accepted.
- s_rd_vld seen in IDLE is ignored and produces no m_rd_vld.
- Only one read is outstanding at a time. Writes from other masters wait until the read returns.
- Reset values (asynchronous, on rst_n = 0):
  - State IDLE; last_grant = NUM_M-1, so master 0 wins first.
  - s_cmd_vld = 0, s_addr = 0, s_data_w = 0, s_rw = 0.
  - m_rd_vld = 0, m_data_r = 0, timeout_err = 0, owner = 0, timeout counter = 0.
- Reset asserted mid-read abandons the read. A slave response arriving after reset release is ignored, per the IDLE rule.

## Timing
- Command latency: the accept in cycle T produces s_cmd_vld = 1 with the payload in T+1, for exactly one cycle.
- Write throughput: one command per cycle. Back-to-back accepts are allowed in consecutive IDLE cycles.
- Read:
  - State is RD_WAIT from T+1.
  - s_rd_vld is sampled from T+1 onward, including the cycle s_cmd_vld is high.
  - s_rd_vld in cycle R gives m_rd_vld[owner] = 1 and m_data_r valid in R+1, for one cycle.
  - State is IDLE in R+1, so a new accept is possible in R+1.
- m_data_r holds its last value after m_rd_vld falls.
- Fairness: with all NUM_M masters requesting continuously, each master is granted exactly once in every NUM_M consecutive accepts.

## Configuration
- PIO_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(RD_TIMEOUT+1) clears on read accept and increments each RD_WAIT cycle without s_rd_vld.
  - When the count reaches RD_TIMEOUT, the next cycle has m_rd_vld[owner] = 1, m_data_r = all-ones and timeout_err = 1 for one cycle, and state returns to IDLE.
  - If s_rd_vld arrives in the same cycle the count reaches RD_TIMEOUT, s_rd_vld wins: real data is returned and no error is flagged.
- Not defined: no counter exists, timeout_err = 0, and RD_WAIT persists until s_rd_vld.

## Test plan
- Reset, then a single write from master 2 (addr 0x0040, data 0xA5A5_0001): m_cmd_rdy[2] = 1 in the same cycle; next cycle s_cmd_vld = 1, s_addr = 0x0040, s_rw = 1; no m_rd_vld.
- All 4 masters issue continuous writes from reset: accept order 0, 1, 2, 3, 0, 1, …; exactly one s_cmd_vld per cycle.
- Master 1 reads 0x0010; slave returns 0x1234_5678 three cycles later: m_rd_vld = 4'b0010 with m_data_r = 0x1234_5678 one cycle after s_rd_vld; master 3's pending write is held (m_cmd_rdy[3] = 0) until then and accepted in the following cycle.
- Slave raises s_rd_vld in the same cycle as s_cmd_vld for the read: the read completes, with m_rd_vld the next cycle. An s_rd_vld pulse in IDLE produces no m_rd_vld.
- With PIO_ARB_TIMEOUT_EN and RD_TIMEOUT = 8, master 0 reads and the slave never responds: m_rd_vld[0] = 1, m_data_r = 0xFFFF_FFFF and timeout_err = 1 together; the next master is accepted afterwards.
- rst_n pulsed low while in RD_WAIT: all outputs return to their reset values immediately; after release, master 0 is granted first.
